instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Write-side companion to the core's instruction memory.
- Accepts a byte stream over a valid/ready handshake: a 2-byte length header followed by 2 bytes per 9-bit machine-code word.
- Writes each word into the instruction ROM's write port at sequential addresses from 0.
- After the last word, pulses the core's start, waits for the core's done, and reports the run length in cycles.

Parameters:
- D, 12, instruction address width (matches program counter width)
- W, 9, machine-code word width
- CW, 16, run-cycle counter width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- load_req  in  1  begin a load; honoured in IDLE and ERR only
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_ready  out  1  loader accepts byte this cycle
- im_wr_en  out  1  instruction memory write strobe
- im_addr  out  D  instruction memory write address
- im_dat  out  W  instruction memory write data
- core_start  out  1  start to core (PC reload)
- core_done  in  1  done from core
- busy  out  1  high in any state other than IDLE and ERR
- err  out  1  sticky framing error
- run_done  out  1  one-cycle pulse when core_done is seen
- run_cycles  out  CW  cycles spent in RUN; saturating; held until next load

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. Every output is 0, including im_addr, im_dat, run_cycles and err. Length and word counters are cleared.
- Byte transfer occurs only when s_valid && s_ready. s_ready is a combinational function of state only: 1 in LEN_LO, LEN_HI, WORD_LO, WORD_HI; 0 elsewhere.
- IDLE:
  - load_req=1 -> LEN_LO, clearing run_cycles and the word counter.
- LEN_LO:
  - On transfer, len[7:0] <= s_data; go to LEN_HI.
- LEN_HI:
  - On transfer with s_data[7:D-8] != 0 -> ERR.
  - Otherwise len[D-1:8] <= s_data[D-9:0].
  - If the resulting len == 0, go to START (no writes). Else go to WORD_LO.
- WORD_LO:
  - On transfer, lo <= s_data; go to WORD_HI.
- WORD_HI:
  - On transfer with s_data[7:1] != 0 -> ERR; no write occurs.
  - Otherwise, next cycle: im_wr_en=1, im_addr=idx, im_dat={s_data[0],lo}. im_wr_en is a registered one-cycle strobe (latency 1 from the accepting edge).
  - idx increments by 1.
  - If idx == len-1 at acceptance, go to START. Else go to WORD_LO.
  - Maximum len is 2^D-1, so idx never wraps.
- START:
  - core_start=1 for exactly one cycle; go to RUN.
  - The final im_wr_en and core_start are asserted in the same cycle. The memory commits on that edge, before the core fetches.
- RUN:
  - run_cycles increments each cycle and saturates at 2^CW-1.
  - core_done=1 -> DONE. The cycle in which done is sampled is counted.
- DONE:
  - run_done=1 for one cycle; go to IDLE.
- ERR:
  - err=1 and held. s_ready=0.
  - load_req=1 -> clear err, go to LEN_LO.
- Stalls: s_valid=0 in any receive state holds state and all registers indefinitely.
- Ignored inputs:
  - core_done is ignored outside RUN.
  - load_req is ignored in LEN_LO..DONE.
- Reset mid-load or mid-run returns to IDLE on the next edge. A partially written program is left in memory; no cleanup writes are issued.
- im_addr and im_dat hold their last values when im_wr_en=0.

Decomposition:
- Package loader_pkg:
  - State enum: IDLE, LEN_LO, LEN_HI, WORD_LO, WORD_HI, START, RUN, DONE, ERR.
  - Constants LOADER_D=12, LOADER_W=9, LOADER_CW=16.
- Single module; no sub-module required.
- The saturating run counter may be an inline always_ff block.

Test Plan:
- Load of 3 words: bytes 03,00, 25,01, FF,00, 07,01 -> three im_wr_en strobes at addr 0,1,2 with dat 0x125, 0x0FF, 0x107; then one core_start pulse in the cycle after the last byte.
- Zero-length load: bytes 00,00 -> no im_wr_en; core_start pulses; drive core_done 5 cycles later -> run_done pulse, run_cycles=6, state IDLE.
- Framing error: length high byte 10 -> err=1, s_ready=0, no writes. Then load_req -> err=0, and a fresh load of 1 word succeeds at addr 0.
- Backpressure gaps: s_valid toggled randomly over a 4-word load -> same writes and addresses as the gap-free run; no duplicate or lost strobes.
- Reset mid-load: rst_n=0 after 2 of 4 words -> next cycle all outputs 0, state IDLE. Stray core_done then produces no run_done.
- Saturation: hold core_done=0 for 70000 RUN cycles -> run_cycles=0xFFFF; core_done -> run_done pulse, value held at 0xFFFF.

Source files
------------

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction loader: the FSM state encoding and
// the default widths used for the instruction address, the machine-code word
// and the run-cycle counter.
// -----------------------------------------------------------------------------
package loader_pkg;

    // Default widths: instruction address (program counter width),
    // machine-code word, and run-cycle counter.
    localparam int LOADER_D  = 12;
    localparam int LOADER_W  = 9;
    localparam int LOADER_CW = 16;

    // Loader sequencing states. LEN_LO..WORD_HI are the byte-receive states,
    // START/RUN/DONE hand the program to the core and time it, ERR is the
    // sticky framing-error state.
    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        WORD_LO,
        WORD_HI,
        START,
        RUN,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Write-side companion to the core's instruction memory. Receives a byte
// stream (2-byte little-endian length, then 2 bytes per machine-code word),
// writes the words to the instruction ROM at addresses 0..len-1, then starts
// the core, waits for it to finish and reports how many cycles it ran.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst_n       synchronous active-low reset
//   load_req    begin a load (honoured in IDLE and ERR only)
//   s_valid     input byte valid
//   s_data      input byte
//   s_ready     loader accepts a byte this cycle (function of state only)
//   im_wr_en    instruction memory write strobe (registered, one cycle)
//   im_addr     instruction memory write address (holds between writes)
//   im_dat      instruction memory write data (holds between writes)
//   core_start  one-cycle start pulse to the core
//   core_done   done from the core (only looked at in RUN)
//   busy        high in every state except IDLE and ERR
//   err         sticky framing error, cleared by the next load
//   run_done    one-cycle pulse after core_done is seen
//   run_cycles  saturating count of cycles spent in RUN
// -----------------------------------------------------------------------------
module instr_loader
    import loader_pkg::*;
#(
    parameter int D  = LOADER_D,
    parameter int W  = LOADER_W,
    parameter int CW = LOADER_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_req,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          im_wr_en,
    output logic [D-1:0]  im_addr,
    output logic [W-1:0]  im_dat,
    output logic          core_start,
    input  logic          core_done,
    output logic          busy,
    output logic          err,
    output logic          run_done,
    output logic [CW-1:0] run_cycles
);

    localparam logic [D-1:0]  D_ONE  = D'(1);
    localparam logic [CW-1:0] CW_ONE = CW'(1);

    loader_state_t state;
    loader_state_t state_next;

    logic [D-1:0] len;
    logic [D-1:0] idx;
    logic [7:0]   lo;

    logic         xfer;
    logic         load_start;
    logic         len_hi_bad;
    logic         word_hi_bad;
    logic         last_word;
    logic [D-1:0] len_full;

    // The loader is ready exactly in the four byte-receive states, so a
    // transfer is simply valid while in one of them.
    assign s_ready    = (state == LEN_LO)  || (state == LEN_HI) ||
                        (state == WORD_LO) || (state == WORD_HI);
    assign xfer       = s_valid && s_ready;
    assign load_start = load_req && ((state == IDLE) || (state == ERR));

    // The length high byte may only carry D-8 significant bits and the word
    // high byte only W-8; anything above that is a framing error.
    assign len_hi_bad  = (s_data >> (D - 8)) != 8'd0;
    assign word_hi_bad = (s_data >> (W - 8)) != 8'd0;

    // Length as it will be once the high byte lands, used to skip straight to
    // START for an empty program.
    assign len_full  = {s_data[D-9:0], len[7:0]};
    assign last_word = (idx == len - D_ONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the status outputs that depend only on state.
    // Defaults describe a busy state with no pulses; each case then only
    // lists what differs from that.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        err        = 1'b0;
        core_start = 1'b0;
        run_done   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (load_req) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) begin
                    if (len_hi_bad)             state_next = ERR;
                    else if (len_full == '0)    state_next = START;
                    else                        state_next = WORD_LO;
                end
            end
            WORD_LO: begin
                if (xfer) state_next = WORD_HI;
            end
            WORD_HI: begin
                if (xfer) begin
                    if (word_hi_bad)    state_next = ERR;
                    else if (last_word) state_next = START;
                    else                state_next = WORD_LO;
                end
            end
            START: begin
                core_start = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (core_done) state_next = DONE;
            end
            DONE: begin
                run_done   = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                busy = 1'b0;
                err  = 1'b1;
                if (load_req) state_next = LEN_LO;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Receive datapath: captures the length and the low byte of each word,
    // and on an accepted high byte issues a registered write so the strobe
    // appears the cycle after acceptance. Address and data are only updated
    // on a write and otherwise hold. A bad high byte writes nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len      <= '0;
            idx      <= '0;
            lo       <= '0;
            im_wr_en <= 1'b0;
            im_addr  <= '0;
            im_dat   <= '0;
        end else begin
            im_wr_en <= 1'b0;
            if (load_start) begin
                idx <= '0;
            end
            case (state)
                LEN_LO: begin
                    if (xfer) len[7:0] <= s_data;
                end
                LEN_HI: begin
                    if (xfer && !len_hi_bad) len[D-1:8] <= s_data[D-9:0];
                end
                WORD_LO: begin
                    if (xfer) lo <= s_data;
                end
                WORD_HI: begin
                    if (xfer && !word_hi_bad) begin
                        im_wr_en <= 1'b1;
                        im_addr  <= idx;
                        im_dat   <= {s_data[W-9:0], lo};
                        idx      <= idx + D_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Run-length counter: cleared when a new load begins, counts every cycle
    // spent in RUN (including the one where core_done is sampled) and sticks
    // at all-ones rather than wrapping. Held untouched after the run ends so
    // software can read it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cycles <= '0;
        end else if (load_start) begin
            run_cycles <= '0;
        end else if ((state == RUN) && (run_cycles != '1)) begin
            run_cycles <= run_cycles + CW_ONE;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
// Directed, self-checking bench for instr_loader. Inputs are driven 1 time
// unit after each rising edge and outputs are sampled at that same point, so
// everything observed is the settled value for the current cycle. A small
// monitor logs every memory write and core_start pulse on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_loader;

    localparam int D  = loader_pkg::LOADER_D;
    localparam int W  = loader_pkg::LOADER_W;
    localparam int CW = loader_pkg::LOADER_CW;

    logic          clk;
    logic          rst_n;
    logic          load_req;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          im_wr_en;
    logic [D-1:0]  im_addr;
    logic [W-1:0]  im_dat;
    logic          core_start;
    logic          core_done;
    logic          busy;
    logic          err;
    logic          run_done;
    logic [CW-1:0] run_cycles;

    int checks   = 0;
    int failures = 0;

    // Observed writes / start pulses (written only by the monitor) and the
    // expected writes (written only by the stimulus process).
    logic [D-1:0] wr_addr_q[$];
    logic [W-1:0] wr_dat_q[$];
    int           start_count = 0;
    logic [D-1:0] exp_addr_q[$];
    logic [W-1:0] exp_dat_q[$];

    instr_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .im_wr_en   (im_wr_en),
        .im_addr    (im_addr),
        .im_dat     (im_dat),
        .core_start (core_start),
        .core_done  (core_done),
        .busy       (busy),
        .err        (err),
        .run_done   (run_done),
        .run_cycles (run_cycles)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write and start-pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (im_wr_en === 1'b1) begin
            wr_addr_q.push_back(im_addr);
            wr_dat_q.push_back(im_dat);
        end
        if (core_start === 1'b1) begin
            start_count++;
        end
    end

    // One comparison: counts it, and on a miss counts a failure and reports.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte after 'gap' idle cycles (with junk on s_data) and wait,
    // bounded, for it to be accepted.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bit accepted;
        accepted = 1'b0;
        s_valid  = 1'b0;
        repeat (gap) begin
            s_data = 8'($urandom);
            tick();
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (s_ready === 1'b1) begin
                tick();
                accepted = 1'b1;
                break;
            end
            tick();
        end
        s_valid = 1'b0;
        if (!accepted) checkOutput("s_ready_timeout", 32'd0, 32'd1);
    endtask

    // Pulse load_req for one cycle.
    task automatic startLoad();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Every output must be zero (reset state).
    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_s_ready"},    32'(s_ready),    32'd0);
        checkOutput({tag, "_im_wr_en"},   32'(im_wr_en),   32'd0);
        checkOutput({tag, "_im_addr"},    32'(im_addr),    32'd0);
        checkOutput({tag, "_im_dat"},     32'(im_dat),     32'd0);
        checkOutput({tag, "_core_start"}, 32'(core_start), 32'd0);
        checkOutput({tag, "_busy"},       32'(busy),       32'd0);
        checkOutput({tag, "_err"},        32'(err),        32'd0);
        checkOutput({tag, "_run_done"},   32'(run_done),   32'd0);
        checkOutput({tag, "_run_cycles"}, 32'(run_cycles), 32'd0);
    endtask

    // Compare writes logged since wbase against expectations queued since ebase.
    task automatic compareLog(input string tag, input int wbase, input int ebase);
        int n;
        n = exp_addr_q.size() - ebase;
        checkOutput({tag, "_wr_count"}, 32'(wr_addr_q.size() - wbase), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (wbase + i < wr_addr_q.size()) begin
                checkOutput($sformatf("%s_wr%0d_addr", tag, i),
                            32'(wr_addr_q[wbase + i]), 32'(exp_addr_q[ebase + i]));
                checkOutput($sformatf("%s_wr%0d_dat", tag, i),
                            32'(wr_dat_q[wbase + i]), 32'(exp_dat_q[ebase + i]));
            end
        end
    endtask

    // Let the core "run" for one cycle and finish it.
    task automatic quickRun(input string tag);
        tick();
        core_done = 1'b1;
        tick();
        checkOutput({tag, "_run_done"}, 32'(run_done), 32'd1);
        core_done = 1'b0;
        tick();
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    logic [7:0] t1_bytes [8] = '{8'h03, 8'h00, 8'h25, 8'h01, 8'hFF, 8'h00, 8'h07, 8'h01};
    logic [7:0] t4_bytes [10] = '{8'h04, 8'h00, 8'h34, 8'h00, 8'h56, 8'h01,
                                  8'h00, 8'h01, 8'h7F, 8'h00};

    initial begin
        int wb;
        int eb;
        int sb;

        rst_n     = 1'b0;
        load_req  = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        core_done = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();
        $display("[TB] reset checked");

        // ---------------- 3-word load ----------------
        wb = wr_addr_q.size();
        eb = exp_addr_q.size();
        sb = start_count;
        startLoad();
        checkOutput("t1_busy",    32'(busy),    32'd1);
        checkOutput("t1_s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(t1_bytes[i], 0);
        checkOutput("t1_core_start", 32'(core_start), 32'd1);
        checkOutput("t1_last_wr_en", 32'(im_wr_en),   32'd1);
        checkOutput("t1_last_addr",  32'(im_addr),    32'd2);
        checkOutput("t1_last_dat",   32'(im_dat),     32'h107);
        exp_addr_q.push_back(12'd0); exp_dat_q.push_back(9'h125);
        exp_addr_q.push_back(12'd1); exp_dat_q.push_back(9'h0FF);
        exp_addr_q.push_back(12'd2); exp_dat_q.push_back(9'h107);
        tick();
        checkOutput("t1_run_start_low", 32'(core_start), 32'd0);
        checkOutput("t1_wr_en_low",     32'(im_wr_en),   32'd0);
        checkOutput("t1_addr_hold",     32'(im_addr),    32'd2);
        checkOutput("t1_dat_hold",      32'(im_dat),     32'h107);
        checkOutput("t1_run_busy",      32'(busy),       32'd1);
        core_done = 1'b1;
        tick();
        checkOutput("t1_run_done",   32'(run_done),   32'd1);
        checkOutput("t1_run_cycles", 32'(run_cycles), 32'd1);
        core_done = 1'b0;
        tick();
        checkOutput("t1_idle_busy",     32'(busy),       32'd0);
        checkOutput("t1_run_done_low",  32'(run_done),   32'd0);
        checkOutput("t1_cycles_held",   32'(run_cycles), 32'd1);
        compareLog("t1", wb, eb);
        checkOutput("t1_start_pulses", 32'(start_count - sb), 32'd1);

        // ---------------- zero-length load ----------------
        wb = wr_addr_q.size();
        sb = start_count;
        startLoad();
        checkOutput("t2_cycles_cleared", 32'(run_cycles), 32'd0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        checkOutput("t2_core_start", 32'(core_start), 32'd1);
        checkOutput("t2_no_wr_en",   32'(im_wr_en),   32'd0);
        tick();
        repeat (5) tick();
        checkOutput("t2_cycles_5", 32'(run_cycles), 32'd5);
        core_done = 1'b1;
        tick();
        checkOutput("t2_run_done",   32'(run_done),   32'd1);
        checkOutput("t2_run_cycles", 32'(run_cycles), 32'd6);
        core_done = 1'b0;
        tick();
        checkOutput("t2_idle_busy",   32'(busy),       32'd0);
        checkOutput("t2_cycles_held", 32'(run_cycles), 32'd6);
        checkOutput("t2_no_writes",   32'(wr_addr_q.size() - wb), 32'd0);
        checkOutput("t2_start_pulses", 32'(start_count - sb), 32'd1);

        // ---------------- framing errors ----------------
        wb = wr_addr_q.size();
        eb = exp_addr_q.size();
        startLoad();
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h00, 0);
        exp_addr_q.push_back(12'd0); exp_dat_q.push_back(9'h011);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h02, 0);
        checkOutput("t3w_err",     32'(err),      32'd1);
        checkOutput("t3w_s_ready", 32'(s_ready),  32'd0);
        checkOutput("t3w_busy",    32'(busy),     32'd0);
        checkOutput("t3w_wr_en",   32'(im_wr_en), 32'd0);
        tick();
        tick();
        checkOutput("t3w_err_sticky", 32'(err), 32'd1);
        startLoad();
        checkOutput("t3_err_cleared", 32'(err),     32'd0);
        checkOutput("t3_reload_rdy",  32'(s_ready), 32'd1);
        applyStimulus(8'h05, 0);
        applyStimulus(8'h10, 0);
        checkOutput("t3l_err",     32'(err),     32'd1);
        checkOutput("t3l_s_ready", 32'(s_ready), 32'd0);
        checkOutput("t3l_wr_en",   32'(im_wr_en), 32'd0);
        startLoad();
        checkOutput("t3l_err_cleared", 32'(err), 32'd0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'h01, 0);
        checkOutput("t3_core_start", 32'(core_start), 32'd1);
        checkOutput("t3_wr_addr",    32'(im_addr),    32'd0);
        checkOutput("t3_wr_dat",     32'(im_dat),     32'h1AA);
        exp_addr_q.push_back(12'd0); exp_dat_q.push_back(9'h1AA);
        quickRun("t3");
        compareLog("t3", wb, eb);

        // ---------------- backpressure gaps ----------------
        wb = wr_addr_q.size();
        eb = exp_addr_q.size();
        sb = start_count;
        startLoad();
        for (int i = 0; i < 10; i++) applyStimulus(t4_bytes[i], int'($urandom_range(0, 3)));
        exp_addr_q.push_back(12'd0); exp_dat_q.push_back(9'h034);
        exp_addr_q.push_back(12'd1); exp_dat_q.push_back(9'h156);
        exp_addr_q.push_back(12'd2); exp_dat_q.push_back(9'h100);
        exp_addr_q.push_back(12'd3); exp_dat_q.push_back(9'h07F);
        checkOutput("t4_core_start", 32'(core_start), 32'd1);
        checkOutput("t4_last_addr",  32'(im_addr),    32'd3);
        quickRun("t4");
        compareLog("t4", wb, eb);
        checkOutput("t4_start_pulses", 32'(start_count - sb), 32'd1);

        // ---------------- reset mid-load ----------------
        wb = wr_addr_q.size();
        eb = exp_addr_q.size();
        sb = start_count;
        startLoad();
        applyStimulus(8'h04, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        exp_addr_q.push_back(12'd0); exp_dat_q.push_back(9'h001);
        exp_addr_q.push_back(12'd1); exp_dat_q.push_back(9'h002);
        rst_n = 1'b0;
        tick();
        checkAllZero("t5_reset");
        rst_n     = 1'b1;
        core_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t5_stray_done_%0d", i), 32'(run_done), 32'd0);
            checkOutput($sformatf("t5_stray_busy_%0d", i), 32'(busy),     32'd0);
        end
        core_done = 1'b0;
        compareLog("t5", wb, eb);
        checkOutput("t5_no_start", 32'(start_count - sb), 32'd0);

        // ---------------- run counter saturation ----------------
        startLoad();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        checkOutput("t6_core_start", 32'(core_start), 32'd1);
        tick();
        repeat (70000) tick();
        checkOutput("t6_saturated", 32'(run_cycles), 32'hFFFF);
        checkOutput("t6_still_busy", 32'(busy), 32'd1);
        core_done = 1'b1;
        tick();
        checkOutput("t6_run_done",  32'(run_done),   32'd1);
        checkOutput("t6_sat_done",  32'(run_cycles), 32'hFFFF);
        core_done = 1'b0;
        tick();
        checkOutput("t6_idle_busy", 32'(busy),       32'd0);
        checkOutput("t6_sat_held",  32'(run_cycles), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
